instruction_fetch: RTL and testbench

- Fetch stage directly upstream of the main decoder.
- Holds the program counter and issues requests to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents its opcode field to the decoder.
- Advances the PC to PC+4, or to a branch target, once the current instruction is released.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/pc_register.sv | 38 +++
 rtl/instruction_fetch.sv | 157 +++++++++++++++
 tb/tb_instruction_fetch.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and the blocks around it.
//   fetch_state_e    : fetch FSM encoding (FETCH=0, WAIT=1, ISSUED=2, HALT=3)
//   OPCODE_WIDTH     : width of the opcode field handed to the decoder
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0) loaded into the IR on reset
//   DEFAULT_RESET_PC : text segment base, default reset value of the PC
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2,
    ST_HALT   = 2'd3
  } fetch_state_e;

  localparam int          OPCODE_WIDTH     = 7;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/pc_register.sv
// Generic DATA_WIDTH register with a load enable and an asynchronous,
// active-low reset to RESET_VALUE. Holds the PC here; intended for reuse as a
// pipeline register.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   load_i : capture d_i on the next rising edge
//   d_i    : next value
//   q_o    : current value
module pc_register #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] value_d;

  always_comb begin
    value_d = load_i ? d_i : value_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= RESET_VALUE;
    end else begin
      value_q <= value_d;
    end
  end

  assign q_o = value_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage feeding the main decoder.
// Holds the PC, requests instruction words over a req/ack handshake, latches
// the returned word into the instruction register and presents its opcode.
// The PC advances (PC+4 or branch target) when the instruction is released.
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   stall_i           : hold the issued instruction
//   branch_taken_i    : take branch_target_i at release
//   branch_target_i   : branch destination
//   imem_req_o/addr_o : instruction memory request and address (= pc_o)
//   imem_ack_i/rdata_i: memory response
//   instr_o, op_o     : instruction register and gated opcode field
//   pc_o, pc_plus4_o  : current PC and PC+4 (link value)
//   instr_valid_o     : instr_o/op_o hold a valid instruction
// Build option FETCH_MISALIGN_CHECK_EN: adds misalign_o; a taken branch to a
// non word-aligned target halts the stage until reset. Without it, the low
// two target bits are cleared instead.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    branch_taken_i,
  input  logic [DATA_WIDTH-1:0]   branch_target_i,
  output logic                    imem_req_o,
  output logic [DATA_WIDTH-1:0]   imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [DATA_WIDTH-1:0]   imem_rdata_i,
  output logic [DATA_WIDTH-1:0]   instr_o,
  output logic [OPCODE_WIDTH-1:0] op_o,
  output logic [DATA_WIDTH-1:0]   pc_o,
  output logic [DATA_WIDTH-1:0]   pc_plus4_o,
  output logic                    instr_valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                    misalign_o
`endif
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  fetch_state_e          state_q, state_d;
  logic                  req_q, req_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  pc_load;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                  misalign_q, misalign_d;
`endif

  pc_register #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_VALUE (RESET_PC)
  ) u_pc_register (
    .clk    (clk),
    .reset  (reset),
    .load_i (pc_load),
    .d_i    (pc_next),
    .q_o    (pc_q)
  );

  // Wraps modulo 2^DATA_WIDTH by construction.
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc_load = 1'b0;
    pc_next = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      ST_FETCH: begin
        req_d   = 1'b1;
        state_d = ST_WAIT;
      end
      // Address is pc_q, which only moves at release, so it is stable here.
      ST_WAIT: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = ST_ISSUED;
        end
      end
      // Branch inputs are only looked at on the release cycle.
      ST_ISSUED: begin
        if (!stall_i) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
          pc_load = 1'b1;
          if (branch_taken_i) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            pc_next = branch_target_i;
            if (branch_target_i[1:0] != 2'b00) begin
              misalign_d = 1'b1;
              state_d    = ST_HALT;
            end
`else
            pc_next = branch_target_i & ALIGN_MASK;
`endif
          end else begin
            pc_next = pc_plus4;
          end
        end
      end
      // HALT: parked until reset, no requests and nothing valid.
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= DATA_WIDTH'(NOP_INSTR);
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  // Zero opcode during fetch gaps keeps the decoder in its no-write default.
  assign op_o          = valid_q ? instr_q[OPCODE_WIDTH-1:0] : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_o    = misalign_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run against a behavioural model of the PC/IR sequence.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [6:0]  op_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int checks;
  int errors;

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_o         (instr_o),
    .op_o            (op_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .instr_valid_o   (instr_valid_o)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o      (misalign_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Advance one cycle; inputs and samples happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    stall_i         = 1'b1;
    branch_taken_i  = 1'b0;
    branch_target_i = '0;
    imem_ack_i      = 1'b0;
    imem_rdata_i    = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Wait (bounded) until a request is visible.
  task automatic await_req(output bit ok);
    for (int i = 0; i < 16 && !imem_req_o; i++) tick();
    ok = imem_req_o;
  endtask

  // Return a word this cycle; stall stays high so the instruction is held.
  task automatic issue_ack(input logic [31:0] word);
    stall_i      = 1'b1;
    imem_ack_i   = 1'b1;
    imem_rdata_i = word;
    tick();
    imem_ack_i   = 1'b0;
  endtask

  task automatic do_release(input bit br, input logic [31:0] tgt);
    stall_i         = 1'b0;
    branch_taken_i  = br;
    branch_target_i = tgt;
    tick();
    branch_taken_i  = 1'b0;
    stall_i         = 1'b1;
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    stall_i         = 1'b1;
    branch_taken_i  = 1'b0;
    branch_target_i = '0;
    imem_ack_i      = 1'b0;
    imem_rdata_i    = '0;
    tick();
    tick();
    checks++; if (pc_o !== RST_PC) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc_o, RST_PC); end
    checks++; if (instr_o !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h expected %h", instr_o, NOP); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req_o); end
    checks++; if (op_o !== 7'd0) begin errors++; $display("[TB] FAIL reset_op: got %h expected 00", op_o); end
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign_o); end
`endif
  endtask

  task automatic test_first_fetch();
    bit ok;
    do_reset();
    tick();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC) begin errors++; $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, RST_PC); end
    issue_ack(32'h0000_0033);
    checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b expected 1", instr_valid_o); end
    checks++; if (op_o !== 7'b0110011) begin errors++; $display("[TB] FAIL first_op: got %b expected 0110011", op_o); end
    checks++; if (pc_o !== RST_PC) begin errors++; $display("[TB] FAIL first_pc: got %h expected %h", pc_o, RST_PC); end
    checks++; if (pc_plus4_o !== RST_PC + 32'd4) begin errors++; $display("[TB] FAIL first_pc4: got %h expected %h", pc_plus4_o, RST_PC + 32'd4); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL first_req_drop: got %b expected 0", imem_req_o); end
    do_release(1'b0, '0);
    await_req(ok);
    checks++; if (!ok || imem_addr_o !== 32'h0040_0004) begin errors++; $display("[TB] FAIL first_next_addr: got ok=%b addr=%h expected 00400004", ok, imem_addr_o); end
  endtask

  task automatic test_wait_stretch();
    bit ok;
    do_reset();
    await_req(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stretch_req: got no request expected request"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC || op_o !== 7'd0) begin
        errors++;
        $display("[TB] FAIL stretch_cycle%0d: got req=%b addr=%h op=%h expected req=1 addr=%h op=00", i, imem_req_o, imem_addr_o, op_o, RST_PC);
      end
      tick();
    end
    issue_ack(32'h1234_5677);
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h1234_5677) begin errors++; $display("[TB] FAIL stretch_latch: got valid=%b instr=%h expected 1 12345677", instr_valid_o, instr_o); end
  endtask

  task automatic test_stall_branch_ignored();
    bit ok;
    do_reset();
    await_req(ok);
    issue_ack(32'h0000_0013);
    for (int i = 0; i < 5; i++) begin
      branch_taken_i  = (i == 2);
      branch_target_i = 32'h0012_3450;
      tick();
      checks++;
      if (pc_o !== RST_PC || instr_valid_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got pc=%h valid=%b expected pc=%h valid=1", i, pc_o, instr_valid_o, RST_PC);
      end
    end
    do_release(1'b0, 32'h0012_3450);
    await_req(ok);
    checks++; if (!ok || imem_addr_o !== RST_PC + 32'd4) begin errors++; $display("[TB] FAIL stall_next_addr: got %h expected %h", imem_addr_o, RST_PC + 32'd4); end
  endtask

  task automatic test_branch();
    bit ok;
    do_reset();
    await_req(ok);
    issue_ack(32'h0000_0063);
    do_release(1'b1, 32'h0040_0100);
    await_req(ok);
    checks++; if (!ok || imem_addr_o !== 32'h0040_0100) begin errors++; $display("[TB] FAIL branch_addr: got %h expected 00400100", imem_addr_o); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    await_req(ok);
    issue_ack(32'h0000_006F);
    do_release(1'b1, 32'hFFFF_FFFC);
    await_req(ok);
    checks++; if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4: got pc=%h pc4=%h expected fffffffc 00000000", pc_o, pc_plus4_o); end
    issue_ack(32'h0000_0013);
    do_release(1'b0, '0);
    checks++; if (pc_o !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc: got %h expected 00000000", pc_o); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    await_req(ok);
    issue_ack(32'h0000_0013);
    do_release(1'b0, '0);
    await_req(ok);
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL async_req: got %b expected 0", imem_req_o); end
    checks++; if (pc_o !== RST_PC) begin errors++; $display("[TB] FAIL async_pc: got %h expected %h", pc_o, RST_PC); end
    tick();
    reset = 1'b1;
    await_req(ok);
    checks++; if (!ok || imem_addr_o !== RST_PC) begin errors++; $display("[TB] FAIL async_restart: got %h expected %h", imem_addr_o, RST_PC); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    bit ok;
    do_reset();
    await_req(ok);
    issue_ack(32'h0000_0063);
    do_release(1'b1, 32'h0040_0102);
    checks++; if (misalign_o !== 1'b1 || pc_o !== 32'h0040_0102 || instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL misalign_set: got mis=%b pc=%h valid=%b expected 1 00400102 0", misalign_o, pc_o, instr_valid_o); end
    for (int i = 0; i < 5; i++) begin
      imem_ack_i = 1'b1;
      tick();
      checks++;
      if (imem_req_o !== 1'b0 || misalign_o !== 1'b1 || instr_valid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL misalign_halt%0d: got req=%b mis=%b valid=%b expected 0 1 0", i, imem_req_o, misalign_o, instr_valid_o);
      end
    end
    imem_ack_i = 1'b0;
  endtask
`endif

  // Random latencies, stalls, branches and stray acks; the model tracks only
  // which PC should be fetched next and which word the IR should hold.
  task automatic test_random();
    bit          ok;
    bit          br;
    logic [31:0] word;
    logic [31:0] tgt;
    logic [31:0] model_pc;
    logic [31:0] model_instr;
    int          lat;
    int          stl;
    do_reset();
    model_pc    = RST_PC;
    model_instr = NOP;
    for (int n = 0; n < 40; n++) begin
      await_req(ok);
      imem_ack_i = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL rand_req_timeout: got no request expected request at %h", model_pc);
        break;
      end
      checks++;
      if (imem_addr_o !== model_pc || pc_plus4_o !== model_pc + 32'd4 || op_o !== 7'd0 ||
          instr_valid_o !== 1'b0 || instr_o !== model_instr) begin
        errors++;
        $display("[TB] FAIL rand_fetch%0d: got addr=%h pc4=%h op=%h valid=%b instr=%h expected %h %h 00 0 %h",
                 n, imem_addr_o, pc_plus4_o, op_o, instr_valid_o, instr_o, model_pc, model_pc + 32'd4, model_instr);
      end
      lat = $urandom_range(0, 3);
      for (int i = 0; i < lat; i++) begin
        tick();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== model_pc) begin
          errors++;
          $display("[TB] FAIL rand_wait%0d: got req=%b addr=%h expected 1 %h", n, imem_req_o, imem_addr_o, model_pc);
        end
      end
      word = $urandom;
      issue_ack(word);
      model_instr = word;
      checks++;
      if (instr_valid_o !== 1'b1 || instr_o !== word || op_o !== word[6:0] || imem_req_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_latch%0d: got valid=%b instr=%h op=%h req=%b expected 1 %h %h 0",
                 n, instr_valid_o, instr_o, op_o, imem_req_o, word, word[6:0]);
      end
      stl = $urandom_range(0, 3);
      for (int i = 0; i < stl; i++) begin
        stall_i         = 1'b1;
        branch_taken_i  = 1'($urandom_range(0, 1));
        branch_target_i = $urandom;
        imem_ack_i      = 1'($urandom_range(0, 1));
        imem_rdata_i    = $urandom;
        tick();
        checks++;
        if (instr_o !== model_instr || pc_o !== model_pc || instr_valid_o !== 1'b1) begin
          errors++;
          $display("[TB] FAIL rand_stall%0d: got instr=%h pc=%h valid=%b expected %h %h 1",
                   n, instr_o, pc_o, instr_valid_o, model_instr, model_pc);
        end
      end
      imem_ack_i = 1'b0;
      br  = ($urandom_range(0, 2) == 0);
      tgt = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      do_release(br, tgt);
      model_pc = br ? (tgt & ~32'h3) : model_pc + 32'd4;
      checks++;
      if (pc_o !== model_pc || instr_valid_o !== 1'b0 || op_o !== 7'd0 || instr_o !== model_instr) begin
        errors++;
        $display("[TB] FAIL rand_release%0d: got pc=%h valid=%b op=%h instr=%h expected %h 0 00 %h",
                 n, pc_o, instr_valid_o, op_o, instr_o, model_pc, model_instr);
      end
      // Stray ack during FETCH must be ignored.
      imem_ack_i   = 1'($urandom_range(0, 1));
      imem_rdata_i = $urandom;
    end
    imem_ack_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_fetch();
    test_wait_stretch();
    test_stall_branch_ignored();
    test_branch();
    test_wrap();
    test_reset_mid_wait();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
